h80_uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` serializer instance among several byte producers, such as the CPU I/O port and a debug monitor. Each requester offers a byte through a valid/ready handshake. The arbiter grants one requester, drives the serializer's enable/data pair and tracks the serializer's busy flag through a full byte. It recovers with an error pulse if the serializer never acknowledges. It sits between the requesters and the `uart_tx` core, in the `sysclk` domain.

---
 rtl/h80_uart_tx_arb_if.sv | 39 +++
 rtl/h80_uart_tx_arb.sv | 174 +++++++++++++++++
 tb/tb_h80_uart_tx_arb.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/h80_uart_tx_arb_if.sv
// Requester and serializer signal bundle for the h80 UART transmit arbiter.
// The master side is the environment (requesters plus uart_tx); the slave side is the arbiter.
interface h80_uart_tx_arb_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2:0]           grant_id;
    logic                 uart_tx_busy;
    logic                 uart_tx_en;
    logic [7:0]           uart_tx_data;
    logic                 timeout_err;

    modport master (
        output req_valid,
        output req_data,
        output req_lock,
        output uart_tx_busy,
        input  req_ready,
        input  grant_id,
        input  uart_tx_en,
        input  uart_tx_data,
        input  timeout_err
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_lock,
        input  uart_tx_busy,
        output req_ready,
        output grant_id,
        output uart_tx_en,
        output uart_tx_data,
        output timeout_err
    );
endinterface

// File: rtl/h80_uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers.
// Optional burst lock (same requester keeps the port while it holds req_lock): define H80_UART_ARB_LOCK_EN.
module h80_uart_tx_arb #(
    parameter int NUM_REQ       = 2,
    parameter int BUSY_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    h80_uart_tx_arb_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_SEND  = 2'b10
    } state_t;

    localparam logic [7:0]         WAIT_MAX_C = 8'(BUSY_WAIT_MAX);
    localparam logic [3:0]         NUM_REQ_C  = 4'(NUM_REQ);
    localparam logic [2:0]         LAST_REQ_C = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_C      = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] ZERO_C     = {NUM_REQ{1'b0}};

    state_t               state_r;
    state_t               state_s;
    logic [7:0]           wait_cnt_r;
    logic [7:0]           wait_cnt_s;
    logic [2:0]           grant_id_r;
    logic [2:0]           grant_id_s;
    logic [NUM_REQ-1:0]   ready_r;
    logic [NUM_REQ-1:0]   ready_s;
    logic                 tx_en_r;
    logic                 tx_en_s;
    logic [7:0]           tx_data_r;
    logic [7:0]           tx_data_s;
    logic                 timeout_r;
    logic                 timeout_s;

    logic [2*NUM_REQ-1:0] valid_dbl_s;
    logic [2*NUM_REQ-1:0] valid_rot_full_s;
    logic [NUM_REQ-1:0]   valid_rot_s;
    logic [NUM_REQ-1:0]   first_hot_s;
    logic [2:0]           rr_offset_s;
    logic [3:0]           rr_sum_s;
    logic [2:0]           rr_win_s;
    logic                 lock_hit_s;
    logic                 win_found_s;
    logic [2:0]           win_id_s;
    logic [8*NUM_REQ-1:0] data_shift_s;

    // Rotate the valid vector so bit 0 is grant_id+1, then pick the lowest set bit.
    always_comb begin
        valid_dbl_s      = {bus.req_valid, bus.req_valid};
        valid_rot_full_s = valid_dbl_s >> ({1'b0, grant_id_r} + 4'd1);
        valid_rot_s      = valid_rot_full_s[NUM_REQ-1:0];
        first_hot_s      = valid_rot_s & (~valid_rot_s + ONE_C);
        rr_offset_s      = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_offset_s = rr_offset_s | (first_hot_s[k] ? 3'(k) : 3'd0);
        end
        rr_sum_s = {1'b0, grant_id_r} + 4'd1 + {1'b0, rr_offset_s};
        rr_win_s = (rr_sum_s >= NUM_REQ_C) ? 3'(rr_sum_s - NUM_REQ_C) : rr_sum_s[2:0];
    end

`ifdef H80_UART_ARB_LOCK_EN
    logic               lock_pri_r;
    logic [NUM_REQ-1:0] lock_rot_s;

    // Lock priority is armed when a byte completes and spent by the next grant; a timeout never arms it.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_pri_r <= 1'b0;
        end else if ((state_r == S_SEND) && (state_s == S_IDLE)) begin
            lock_pri_r <= 1'b1;
        end else if ((state_r == S_IDLE) && (state_s == S_START)) begin
            lock_pri_r <= 1'b0;
        end else begin
            lock_pri_r <= lock_pri_r;
        end
    end

    assign lock_rot_s = (bus.req_lock & bus.req_valid) >> grant_id_r;
    assign lock_hit_s = lock_pri_r & lock_rot_s[0];
`else
    logic unused_lock_s;

    assign unused_lock_s = ^bus.req_lock;
    assign lock_hit_s    = 1'b0;
`endif

    assign win_found_s  = lock_hit_s | (|bus.req_valid);
    assign win_id_s     = lock_hit_s ? grant_id_r : rr_win_s;
    assign data_shift_s = bus.req_data >> {win_id_s, 3'b000};

    // Next-state and next-output logic for the grant / start / send sequence.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        grant_id_s = grant_id_r;
        ready_s    = ZERO_C;
        tx_en_s    = tx_en_r;
        tx_data_s  = tx_data_r;
        timeout_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!bus.uart_tx_busy && win_found_s) begin
                    grant_id_s = win_id_s;
                    ready_s    = ONE_C << win_id_s;
                    tx_data_s  = data_shift_s[7:0];
                    tx_en_s    = 1'b1;
                    wait_cnt_s = 8'd0;
                    state_s    = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (bus.uart_tx_busy) begin
                    tx_en_s    = 1'b0;
                    wait_cnt_s = 8'd0;
                    state_s    = S_SEND;
                end else if (wait_cnt_r == WAIT_MAX_C) begin
                    // Serializer never acknowledged: drop the byte, requester was already released.
                    tx_en_s    = 1'b0;
                    timeout_s  = 1'b1;
                    wait_cnt_s = 8'd0;
                    state_s    = S_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            S_SEND: begin
                if (!bus.uart_tx_busy) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_SEND;
                end
            end
            default: begin
                tx_en_s    = 1'b0;
                wait_cnt_s = 8'd0;
                state_s    = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 first in rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= 8'd0;
            grant_id_r <= LAST_REQ_C;
            ready_r    <= ZERO_C;
            tx_en_r    <= 1'b0;
            tx_data_r  <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            grant_id_r <= grant_id_s;
            ready_r    <= ready_s;
            tx_en_r    <= tx_en_s;
            tx_data_r  <= tx_data_s;
            timeout_r  <= timeout_s;
        end
    end

    assign bus.req_ready    = ready_r;
    assign bus.grant_id     = grant_id_r;
    assign bus.uart_tx_en   = tx_en_r;
    assign bus.uart_tx_data = tx_data_r;
    assign bus.timeout_err  = timeout_r;

endmodule

// File: tb/tb_h80_uart_tx_arb.sv
// Self-checking bench for h80_uart_tx_arb: transaction-level reference model, per-cycle compare,
// directed scenarios with hand-computed grant orders. Honors H80_UART_ARB_LOCK_EN when defined.
module tb_h80_uart_tx_arb;

    localparam int NUM_REQ       = 2;
    localparam int BUSY_WAIT_MAX = 15;
    localparam int BD            = 2;   // busy rises this many cycles after en is seen
    localparam int BL            = 20;  // busy stays high this many cycles
`ifdef H80_UART_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    h80_uart_tx_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    h80_uart_tx_arb #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_WAIT_MAX(BUSY_WAIT_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [1:0]  lock_mode;
    int          busy_mode;   // 0 auto serializer, 1 never busy, 2 held busy
    bit          srl_active;
    int          srl_sc;
    logic [10:0] obs_q[$];
    int          en_hi;
    int          terr_seen;
    int          ready_seen;
    bit          chk_on;

    logic [1:0]  m_ready;
    logic        m_en;
    logic [7:0]  m_data;
    logic        m_terr;
    logic [2:0]  m_gid;
    int          m_phase;     // 0 waiting for work, 1 waiting for busy, 2 byte on the wire
    int          m_elapsed;
    bit          m_lockpri;
    int          m_win;

    function automatic int next_owner(logic [1:0] v, logic [1:0] lk, logic [2:0] gid, bit lp);
        if (LOCK_ON && lp && v[gid] && lk[gid]) return int'(gid);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c = (int'(gid) + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    always_comb m_win = next_owner(bus.req_valid, bus.req_lock, m_gid, m_lockpri);

    // Reference model: one step of the arbitration rules per clock
    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0; m_ready <= 2'b00; m_en <= 1'b0; m_data <= 8'h00; m_terr <= 1'b0;
            m_gid <= 3'(NUM_REQ - 1); m_elapsed <= 0; m_lockpri <= 1'b0;
        end else begin
            m_ready <= 2'b00;
            m_terr  <= 1'b0;
            if (m_phase == 0) begin
                if (!bus.uart_tx_busy && m_win >= 0) begin
                    m_gid     <= 3'(m_win);
                    m_ready   <= 2'(1 << m_win);
                    m_data    <= bus.req_data[8*m_win +: 8];
                    m_en      <= 1'b1;
                    m_phase   <= 1;
                    m_elapsed <= 0;
                    m_lockpri <= 1'b0;
                end
            end else if (m_phase == 1) begin
                if (bus.uart_tx_busy) begin
                    m_en <= 1'b0; m_phase <= 2;
                end else if (m_elapsed == BUSY_WAIT_MAX) begin
                    m_en <= 1'b0; m_terr <= 1'b1; m_phase <= 0;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end else if (!bus.uart_tx_busy) begin
                m_phase <= 0; m_lockpri <= 1'b1;
            end
        end
    end

    // Per-cycle compare of all DUT outputs against the model, plus event logging
    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready",    32'(bus.req_ready),    32'(m_ready));
            chk("uart_tx_en",   32'(bus.uart_tx_en),   32'(m_en));
            chk("uart_tx_data", 32'(bus.uart_tx_data), 32'(m_data));
            chk("timeout_err",  32'(bus.timeout_err),  32'(m_terr));
            chk("grant_id",     32'(bus.grant_id),     32'(m_gid));
            if (bus.req_ready != 2'b00) begin
                obs_q.push_back({bus.grant_id, bus.uart_tx_data});
                ready_seen++;
            end
            if (bus.uart_tx_en) en_hi++;
            if (bus.timeout_err) terr_seen++;
        end
    end

    task automatic tick();
        logic [7:0] tmp;
        @(negedge clk);
        if (bus.req_ready[0] && q0.size() > 0) tmp = q0.pop_front();
        if (bus.req_ready[1] && q1.size() > 0) tmp = q1.pop_front();
        case (busy_mode)
            0: begin
                if (!srl_active && bus.uart_tx_en) begin
                    srl_active = 1'b1;
                    srl_sc     = 0;
                end
                if (srl_active) begin
                    srl_sc++;
                    if (srl_sc >= BD + BL) begin
                        srl_active       = 1'b0;
                        bus.uart_tx_busy = 1'b0;
                    end else begin
                        bus.uart_tx_busy = (srl_sc >= BD);
                    end
                end else begin
                    bus.uart_tx_busy = 1'b0;
                end
            end
            1: begin srl_active = 1'b0; bus.uart_tx_busy = 1'b0; end
            default: begin srl_active = 1'b0; bus.uart_tx_busy = 1'b1; end
        endcase
        bus.req_valid = {q1.size() > 0, q0.size() > 0};
        bus.req_data  = {(q1.size() > 0) ? q1[0] : 8'h00, (q0.size() > 0) ? q0[0] : 8'h00};
        bus.req_lock  = lock_mode & bus.req_valid;
    endtask

    task automatic clear_log();
        obs_q.delete();
        en_hi = 0; terr_seen = 0; ready_seen = 0;
    endtask

    task automatic wait_quiet(input int budget);
        int quiet = 0;
        int n     = 0;
        while (quiet < 3 && n < budget) begin
            tick();
            n++;
            if (q0.size() == 0 && q1.size() == 0 && m_phase == 0 && !bus.uart_tx_busy &&
                !bus.uart_tx_en && !srl_active) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            vectors++; miscompares++;
            $display("FAIL wait_quiet: actual=still active required=idle within %0d cycles", budget);
        end
    endtask

    task automatic check_order(string name, logic [10:0] exp[6]);
        chk({name, "_count"}, 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk(name, (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF, 32'(exp[i]));
        end
    endtask

    logic [10:0] exp6[6];

    initial begin
        reset = 1'b1; busy_mode = 0; lock_mode = 2'b00; srl_active = 1'b0; srl_sc = 0; chk_on = 1'b0;
        en_hi = 0; terr_seen = 0; ready_seen = 0;
        bus.req_valid = 2'b00; bus.req_data = 16'h0000; bus.req_lock = 2'b00; bus.uart_tx_busy = 1'b0;
        tick();
        chk_on = 1'b1;
        tick(); tick();
        chk("rst_grant_id", 32'(bus.grant_id), 32'd1);
        chk("rst_en", 32'(bus.uart_tx_en), 32'd0);
        chk("rst_data", 32'(bus.uart_tx_data), 32'd0);
        reset = 1'b0;

        // Single byte from requester 0
        clear_log();
        q0.push_back(8'h41);
        wait_quiet(200);
        chk("t1_grants", 32'(obs_q.size()), 32'd1);
        chk("t1_entry", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF, 32'h041);
        chk("t1_en_cycles", 32'(en_hi), 32'd2);
        chk("t1_grant_id", 32'(bus.grant_id), 32'd0);

        // Two requesters, four bytes each, strict alternation from requester 0
        reset = 1'b1; tick(); reset = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) begin q0.push_back(8'h10); q1.push_back(8'h20); end
        wait_quiet(600);
        chk("t2_count", 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF,
                (i % 2 == 0) ? 32'h010 : 32'h120);
        end

        // Serializer never acknowledges
        clear_log();
        busy_mode = 1;
        q0.push_back(8'h55);
        wait_quiet(200);
        chk("t3_timeout_pulses", 32'(terr_seen), 32'd1);
        chk("t3_en_cycles", 32'(en_hi), 32'(BUSY_WAIT_MAX + 1));
        busy_mode = 0;
        clear_log();
        q1.push_back(8'h66);
        wait_quiet(200);
        chk("t3_next_entry", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF, 32'h166);
        chk("t3_no_timeout", 32'(terr_seen), 32'd0);

        // Reset in the middle of a byte
        clear_log();
        q0.push_back(8'h77);
        for (int n = 0; n < 60 && !(srl_active && srl_sc >= BD + 5); n++) tick();
        reset = 1'b1;
        tick();
        chk("t4_en", 32'(bus.uart_tx_en), 32'd0);
        chk("t4_ready", 32'(bus.req_ready), 32'd0);
        chk("t4_data", 32'(bus.uart_tx_data), 32'd0);
        chk("t4_gid", 32'(bus.grant_id), 32'd1);
        reset = 1'b0;
        wait_quiet(200);
        clear_log();
        q0.push_back(8'hA0); q1.push_back(8'hA1);
        wait_quiet(300);
        chk("t4_first", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF, 32'h0A0);
        chk("t4_second", (obs_q.size() > 1) ? 32'(obs_q[1]) : 32'hFFFF, 32'h1A1);

        // Busy held high with a pending request
        clear_log();
        busy_mode = 2;
        q0.push_back(8'hB5);
        for (int n = 0; n < 10; n++) tick();
        chk("t5_no_ready", 32'(ready_seen), 32'd0);
        busy_mode = 0;
        wait_quiet(200);
        chk("t5_ready_once", 32'(ready_seen), 32'd1);
        chk("t5_entry", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF, 32'h0B5);

        // Requester 1 bursts three bytes under lock while requester 0 waits
        clear_log();
        lock_mode = 2'b10;
        q1.push_back(8'hC1); q1.push_back(8'hC2); q1.push_back(8'hC3);
        for (int n = 0; n < 100 && ready_seen == 0; n++) tick();
        q0.push_back(8'hD1); q0.push_back(8'hD2); q0.push_back(8'hD3);
        wait_quiet(600);
`ifdef H80_UART_ARB_LOCK_EN
        exp6 = '{11'h1C1, 11'h1C2, 11'h1C3, 11'h0D1, 11'h0D2, 11'h0D3};
`else
        exp6 = '{11'h1C1, 11'h0D1, 11'h1C2, 11'h0D2, 11'h1C3, 11'h0D3};
`endif
        check_order("t6_order", exp6);
        lock_mode = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
